// File: rtl/avalon_rr_arbiter.sv
// avalon_rr_arbiter: two-host round-robin Avalon-MM arbiter with write-burst lock and read-response routing.
// Optional grant/stall statistics are enabled by defining AVALON_ARB_STATS_EN.
module avalon_rr_arbiter #(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 32,
    parameter int BURST_W        = 8,
    parameter int RD_TRACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     h0_address,
    input  logic [BURST_W-1:0]    h0_burstcount,
    input  logic                  h0_write,
    input  logic                  h0_read,
    input  logic [DATA_W-1:0]     h0_writedata,
    input  logic [DATA_W/8-1:0]   h0_byteenable,
    output logic                  h0_waitrequest,
    output logic                  h0_readdatavalid,
    output logic [DATA_W-1:0]     h0_readdata,
    input  logic [ADDR_W-1:0]     h1_address,
    input  logic [BURST_W-1:0]    h1_burstcount,
    input  logic                  h1_write,
    input  logic                  h1_read,
    input  logic [DATA_W-1:0]     h1_writedata,
    input  logic [DATA_W/8-1:0]   h1_byteenable,
    output logic                  h1_waitrequest,
    output logic                  h1_readdatavalid,
    output logic [DATA_W-1:0]     h1_readdata,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic                  avm_write,
    output logic                  avm_read,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    input  logic [DATA_W-1:0]     avm_readdata,
    output logic                  rd_route_err
`ifdef AVALON_ARB_STATS_EN
    ,
    output logic [31:0]           h0_grant_cnt,
    output logic [31:0]           h1_grant_cnt,
    output logic [31:0]           arb_stall_cnt
`endif
);
    localparam int PW = $clog2(RD_TRACK_DEPTH);

    typedef enum logic {IDLE, WR_BURST} state_t;

    state_t               state, state_nx;
    logic                 last_grant, owner;
    logic [BURST_W-1:0]   beats_left;
    logic                 tr_owner [RD_TRACK_DEPTH];
    logic [BURST_W-1:0]   tr_rem   [RD_TRACK_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          count;
    logic                 full, empty, elig0, elig1, gnt_valid, sel;
    logic                 sel_write, sel_read, acc, push, pop, rd_hit;
    logic [BURST_W-1:0]   sel_bc;

    assign h0_readdata = avm_readdata;
    assign h1_readdata = avm_readdata;

    always_comb begin
        full             = count == (PW+1)'(RD_TRACK_DEPTH);
        empty            = count == '0;
        elig0            = h0_write | (h0_read & ~full);
        elig1            = h1_write | (h1_read & ~full);
        gnt_valid        = (state == WR_BURST) | elig0 | elig1;
        sel              = (state == WR_BURST) ? owner : (elig0 & elig1) ? ~last_grant : elig1;
        sel_write        = sel ? h1_write : h0_write;
        sel_read         = sel ? h1_read : h0_read;
        sel_bc           = sel ? h1_burstcount : h0_burstcount;
        avm_write        = gnt_valid & sel_write;
        // a host driving write and read together gets its write first
        avm_read         = gnt_valid & (state == IDLE) & sel_read & ~sel_write & ~full;
        avm_address      = gnt_valid ? (sel ? h1_address : h0_address) : '0;
        avm_burstcount   = gnt_valid ? sel_bc : '0;
        avm_writedata    = gnt_valid ? (sel ? h1_writedata : h0_writedata) : '0;
        avm_byteenable   = gnt_valid ? (sel ? h1_byteenable : h0_byteenable) : '0;
        h0_waitrequest   = ~(gnt_valid & ~sel) | avm_waitrequest;
        h1_waitrequest   = ~(gnt_valid & sel) | avm_waitrequest;
        acc              = (avm_write | avm_read) & ~avm_waitrequest;
        push             = avm_read & ~avm_waitrequest;
        rd_hit           = avm_readdatavalid & ~empty;
        h0_readdatavalid = rd_hit & ~tr_owner[rd_ptr];
        h1_readdatavalid = rd_hit & tr_owner[rd_ptr];
        pop              = rd_hit & (tr_rem[rd_ptr] <= BURST_W'(1));
        state_nx         = state;
        if (state == IDLE && acc && avm_write && sel_bc > BURST_W'(1))
            state_nx = WR_BURST;
        if (state == WR_BURST && acc && beats_left == BURST_W'(1))
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            beats_left   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_route_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc && state == IDLE) begin
                last_grant <= sel;
                owner      <= sel;
                beats_left <= sel_bc - BURST_W'(1);
            end else if (acc) begin
                beats_left <= beats_left - BURST_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (avm_readdatavalid && empty)
                rd_route_err <= 1'b1;
        end
    end

    // tracker payload needs no reset: entries are only read while count is nonzero
    always_ff @(posedge clk) begin
        if (push) begin
            tr_owner[wr_ptr] <= sel;
            tr_rem[wr_ptr]   <= (sel_bc == '0) ? BURST_W'(1) : sel_bc;
        end
        if (rd_hit && !pop)
            tr_rem[rd_ptr] <= tr_rem[rd_ptr] - BURST_W'(1);
    end

`ifdef AVALON_ARB_STATS_EN
    logic stall0, stall1;

    assign stall0 = (h0_write | h0_read) & ~(gnt_valid & ~sel);
    assign stall1 = (h1_write | h1_read) & ~(gnt_valid & sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_grant_cnt  <= '0;
            h1_grant_cnt  <= '0;
            arb_stall_cnt <= '0;
        end else begin
            if (acc && state == IDLE && !sel)
                h0_grant_cnt <= h0_grant_cnt + 32'd1;
            if (acc && state == IDLE && sel)
                h1_grant_cnt <= h1_grant_cnt + 32'd1;
            if (stall0 || stall1)
                arb_stall_cnt <= arb_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// tb_avalon_rr_arbiter: directed scoreboard bench for avalon_rr_arbiter (command order and read routing).
module tb_avalon_rr_arbiter;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int BURST_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ADDR_W-1:0] h0_address, h1_address, avm_address;
    logic [BURST_W-1:0] h0_burstcount, h1_burstcount, avm_burstcount;
    logic h0_write, h0_read, h1_write, h1_read;
    logic [DATA_W-1:0] h0_writedata, h1_writedata, avm_writedata;
    logic [DATA_W/8-1:0] h0_byteenable, h1_byteenable, avm_byteenable;
    logic h0_waitrequest, h1_waitrequest, h0_readdatavalid, h1_readdatavalid;
    logic [DATA_W-1:0] h0_readdata, h1_readdata, avm_readdata;
    logic avm_write, avm_read, avm_waitrequest, avm_readdatavalid, rd_route_err;
`ifdef AVALON_ARB_STATS_EN
    logic [31:0] h0_grant_cnt, h1_grant_cnt, arb_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [21:0] cq[$];
    bit rq[$];

    always #5 clk = ~clk;

    avalon_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .h0_address(h0_address), .h0_burstcount(h0_burstcount), .h0_write(h0_write),
        .h0_read(h0_read), .h0_writedata(h0_writedata), .h0_byteenable(h0_byteenable),
        .h0_waitrequest(h0_waitrequest), .h0_readdatavalid(h0_readdatavalid), .h0_readdata(h0_readdata),
        .h1_address(h1_address), .h1_burstcount(h1_burstcount), .h1_write(h1_write),
        .h1_read(h1_read), .h1_writedata(h1_writedata), .h1_byteenable(h1_byteenable),
        .h1_waitrequest(h1_waitrequest), .h1_readdatavalid(h1_readdatavalid), .h1_readdata(h1_readdata),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
        .avm_read(avm_read), .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .rd_route_err(rd_route_err)
`ifdef AVALON_ARB_STATS_EN
        , .h0_grant_cnt(h0_grant_cnt), .h1_grant_cnt(h1_grant_cnt), .arb_stall_cnt(arb_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] pc(input bit host, input bit rd, input int bc, input int addr);
        logic [3:0] b;
        logic [15:0] a;
        b = bc[3:0];
        a = addr[15:0];
        return {host, rd, b, a};
    endfunction

    // compare accepted commands and routed read beats against the scoreboard queues
    task automatic mon();
        logic [21:0] e;
        logic [1:0] r;
        if ((avm_write || avm_read) && !avm_waitrequest) begin
            e = (cq.size() != 0) ? cq.pop_front() : 22'h3fffff;
            chk("cmd", {!h1_waitrequest, avm_read, avm_burstcount[3:0], avm_address[15:0]}, e);
        end
        if (avm_readdatavalid) begin
            r = (rq.size() != 0) ? (rq.pop_front() ? 2'b10 : 2'b01) : 2'b00;
            chk("route", {h1_readdatavalid, h0_readdatavalid}, r);
            chk("rdata", h1_readdata[63:0] ^ h0_readdata[63:0], 64'h0);
            chk("rdata_val", h0_readdata[63:0], avm_readdata[63:0]);
        end else begin
            chk("rdv_idle", {h1_readdatavalid, h0_readdatavalid}, 2'b00);
        end
    endtask

    task automatic settle();
        #1;
        mon();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        {h0_write, h0_read, h1_write, h1_read} = '0;
        h0_address = '0; h1_address = '0;
        h0_burstcount = 8'd1; h1_burstcount = 8'd1;
        h0_writedata = {4{32'hA0A0_0000}}; h1_writedata = {4{32'hB1B1_0000}};
        h0_byteenable = '1; h1_byteenable = '1;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cq.delete();
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // reset values
        do_reset();
        settle();
        chk("rst_avm_cmd", {avm_write, avm_read}, 2'b00);
        chk("rst_wait", {h1_waitrequest, h0_waitrequest}, 2'b11);
        chk("rst_err", rd_route_err, 1'b0);
        tick();
        // 4-beat write burst locks out a concurrent read
        h0_address = 32'h100; h0_burstcount = 8'd4;
        h1_address = 32'h200; h1_burstcount = 8'd1;
        for (int i = 0; i < 4; i++) cq.push_back(pc(0, 0, 4, 'h100));
        cq.push_back(pc(1, 1, 1, 'h200));
        rq.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            h0_write = (i < 4);
            h1_read = (i >= 1);
            settle();
            if (i >= 1 && i < 4) chk("t1_h1_locked", h1_waitrequest, 1'b1);
            if (i == 4) chk("t1_read_after", avm_read, 1'b1);
            tick();
        end
        h1_read = 1'b0;
        chk("t1_cq_empty", cq.size(), 0);
        avm_readdatavalid = 1'b1; avm_readdata = {4{32'h1234_5678}};
        cyc();
        avm_readdatavalid = 1'b0;
        chk("t1_rq_empty", rq.size(), 0);
        // alternating single writes, host0 first after reset
        do_reset();
        h0_address = 32'h1000; h1_address = 32'h2000;
        for (int i = 0; i < 8; i++) cq.push_back((i % 2 == 0) ? pc(0, 0, 1, 'h1000) : pc(1, 0, 1, 'h2000));
        h0_write = 1'b1; h1_write = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        h0_write = 1'b0; h1_write = 1'b0;
        chk("t2_cq_empty", cq.size(), 0);
        // read routing: host1 burst 2 then host0 burst 3
        h1_read = 1'b1; h1_burstcount = 8'd2; h1_address = 32'h300;
        cq.push_back(pc(1, 1, 2, 'h300));
        cyc();
        h1_read = 1'b0;
        h0_read = 1'b1; h0_burstcount = 8'd3; h0_address = 32'h400;
        cq.push_back(pc(0, 1, 3, 'h400));
        cyc();
        h0_read = 1'b0;
        rq.push_back(1'b1); rq.push_back(1'b1);
        rq.push_back(1'b0); rq.push_back(1'b0); rq.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            avm_readdatavalid = 1'b1; avm_readdata = DATA_W'(i + 32'h55);
            cyc();
        end
        avm_readdatavalid = 1'b0;
        chk("t3_rq_empty", rq.size(), 0);
        chk("t3_cq_empty", cq.size(), 0);
        chk("t3_err", rd_route_err, 1'b0);
        // tracker full: 5th read stalls while a host0 write proceeds
        h1_read = 1'b1; h1_burstcount = 8'd1; h1_address = 32'h600;
        for (int i = 0; i < 4; i++) begin
            cq.push_back(pc(1, 1, 1, 'h600));
            rq.push_back(1'b1);
            cyc();
        end
        h0_write = 1'b1; h0_burstcount = 8'd1; h0_address = 32'h700;
        cq.push_back(pc(0, 0, 1, 'h700));
        settle();
        chk("t4_full_stall", h1_waitrequest, 1'b1);
        chk("t4_write_go", avm_write, 1'b1);
        tick();
        h0_write = 1'b0;
        avm_readdatavalid = 1'b1;
        settle();
        chk("t4_still_full", h1_waitrequest, 1'b1);
        tick();
        avm_readdatavalid = 1'b0;
        cq.push_back(pc(1, 1, 1, 'h600));
        rq.push_back(1'b1);
        settle();
        chk("t4_fifth_go", h1_waitrequest, 1'b0);
        tick();
        h1_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1'b1;
            cyc();
        end
        avm_readdatavalid = 1'b0;
        chk("t4_rq_empty", rq.size(), 0);
        chk("t4_cq_empty", cq.size(), 0);
        // readdatavalid with empty tracker
        avm_readdatavalid = 1'b1;
        cyc();
        avm_readdatavalid = 1'b0;
        settle();
        chk("t5_err_set", rd_route_err, 1'b1);
        tick();
        repeat (3) cyc();
        chk("t5_err_hold", rd_route_err, 1'b1);
        // reset mid-burst with a read outstanding
        do_reset();
        chk("t6_err_clr", rd_route_err, 1'b0);
        h1_read = 1'b1; h1_address = 32'h800;
        cq.push_back(pc(1, 1, 1, 'h800));
        cyc();
        h1_read = 1'b0;
        h0_write = 1'b1; h0_burstcount = 8'd4; h0_address = 32'h500;
        cq.push_back(pc(0, 0, 4, 'h500));
        cq.push_back(pc(0, 0, 4, 'h500));
        cyc();
        cyc();
        rst_n = 1'b0;
        h0_write = 1'b0;
        settle();
        chk("t6_rst_cmd", {avm_write, avm_read}, 2'b00);
        chk("t6_rst_wait", {h1_waitrequest, h0_waitrequest}, 2'b11);
        chk("t6_cq_empty", cq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        h0_burstcount = 8'd1; h0_address = 32'h900;
        h1_burstcount = 8'd1; h1_address = 32'hA00;
        cq.push_back(pc(0, 0, 1, 'h900));
        cq.push_back(pc(1, 0, 1, 'hA00));
        h0_write = 1'b1; h1_write = 1'b1;
        cyc();
        cyc();
        h0_write = 1'b0; h1_write = 1'b0;
        chk("t6_post_cq", cq.size(), 0);
        avm_readdatavalid = 1'b1;
        cyc();
        avm_readdatavalid = 1'b0;
        settle();
        chk("t6_tracker_empty", rd_route_err, 1'b1);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
